fpu_norm_round_pipe: RTL and testbench
======================================

// Module: fpu_norm_round_pipe
// PURPOSE
//  Pipelined, parametrised normalise/round/pack stage for the div/sqrt datapath. Accepts the raw
//  quotient/root (mantissa + guard + sticky, signed biased exponent) and special-operand flags.
//  Produces an IEEE-754 packed result plus the full exception-flag set. Adds over the combinational
//  normaliser: parametric format, 2-stage valid/ready pipeline, RMM rounding, RM-dependent overflow
//  saturation, NX/NV flags, tag passthrough and flush. Sits between the iteration unit and the
//  FPU writeback arbiter.
// PARAMETERS
//  C_EXP        8   exponent width (E); bias = 2^(E-1)-1
//  C_MANT       23  stored mantissa width (M)
//  C_TAG_WIDTH  4   width of opaque tag carried alongside each operation
// PORTS
//  Clk_CI        in   1      clock
//  Rst_RBI       in   1      synchronous active-low reset
//  Flush_SI      in   1      drop all in-flight entries
//  In_valid_SI   in   1      input entry valid
//  In_ready_SO   out  1      block can accept input this cycle
//  Mant_in_DI    in   M+2    {int bit, M fraction bits, guard}; int bit 0 means value is 0.1x (needs 1 left shift)
//  Sticky_in_SI  in   1      OR of all bits below guard
//  Exp_in_DI     in   E+2    signed biased exponent (two's complement)
//  Sign_in_DI    in   1      result sign
//  Div_enable_SI in   1      1 = divide, 0 = sqrt
//  Inf_a_SI, Inf_b_SI, Zero_a_SI, Zero_b_SI, NaN_a_SI, NaN_b_SI  in 1 each  operand class
//  RM_SI         in   3      000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; others treated as RNE
//  Tag_DI        in   C_TAG_WIDTH  opaque tag
//  Out_valid_SO  out  1      result valid
//  Out_ready_SI  in   1      consumer accepts result
//  Result_DO     out  E+M+1  {sign, exp, mant}
//  Flags_DO      out  5      {NV, DZ, OF, UF, NX}
//  Tag_DO        out  C_TAG_WIDTH  tag of Result_DO
// BEHAVIOUR
//  Reset (Rst_RBI=0 at posedge): both stage valids 0; Out_valid_SO=0; Result_DO, Flags_DO, Tag_DO = 0.
//  Handshake: transfer on valid&ready. In_ready_SO = ~S1_valid | S1 advances; S1 advances when ~S2_valid | Out_ready_SI.
//   Latency exactly 2 cycles with no backpressure; throughput 1/cycle; outputs stable while valid&~ready.
//  Flush_SI=1: both stage valids cleared next edge; input offered that cycle is dropped; outputs not-valid next cycle.
//  Stage 1 (classify + normalise), priority order:
//   NaN_a|NaN_b -> qNaN {0,all-1s,10..0}, NV=1 only if a NaN is signalling (frac MSB=0, passed as NaN_x with Zero_x=1);
//   div inf/inf, div 0/0, sqrt of negative non-zero -> qNaN, NV=1; div x/0 (x finite non-zero) -> +/-inf, DZ=1;
//   Inf_a -> +/-inf; div x/inf -> +/-0; Zero_a -> +/-0 (sqrt(-0) = -0).
//   Otherwise: if int bit 0, shift left 1 and exp-1. If exp<=0: right-shift by (1-exp), shifted-out bits OR into
//   sticky; shift >= M+3 leaves only sticky; exp forced 0 (subnormal/zero). If exp >= 2^E-1: overflow.
//  Stage 2 (round + pack): G=guard, S=sticky|lower bits; NX = G|S.
//   RNE: up = G&(S|lsb); RTZ: 0; RDN: NX&sign; RUP: NX&~sign; RMM: G.
//   Mantissa carry-out: normal -> exp+1, mant>>1; subnormal carry into hidden bit -> exp=1 (becomes normal).
//   Rounding to exp=2^E-1 is overflow.
//  Overflow: OF=1, NX=1; result = inf for RNE/RMM, RUP&+, RDN&-; else max finite {exp=2^E-2, mant=all-1s}.
//  UF=1 iff final result is subnormal or zero after rounding from a non-zero finite input AND NX=1 (tininess after rounding).
//  Special results: OF/UF/NX=0 except as listed above.
// TESTING
//  RNE tie: exp 127, Mant {1,0x000001,G=1}, S=0 -> 0x3F800002, flags 00001; same with mant 0x000000 -> 0x3F800000.
//  RTZ overflow: exp 255, sign 0, normal mant -> 0x7F7FFFFF, Flags 00101; RNE same input -> 0x7F800000.
//  Subnormal: exp -2, Mant {1,0,G=0}, sticky 1, RNE -> 0x00100000, Flags 00011 (UF, NX).
//  Div 0/0 -> 0x7FC00000 Flags 10000; div 1/0 sign 1 -> 0xFF800000 Flags 01000; sqrt(-4) -> 0x7FC00000 NV.
//  Backpressure: 4 back-to-back inputs, Out_ready_SI low 3 cycles -> In_ready_SO drops after 2 accepted;
//   all 4 results emerge in order with correct tags, none duplicated.
//  Flush with 2 in flight, and Rst_RBI low mid-stream -> Out_valid_SO 0 next cycle; next input's result emerges 2 cycles after accept.

Source files
------------

// File: rtl/fpu_norm_round_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// fpu_norm_round_pipe: 2-stage normalise/round/pack of div/sqrt results to IEEE-754 with flags
// Revision 1.0
// ============================================================================
module fpu_norm_round_pipe #(
  parameter int C_EXP       = 8,
  parameter int C_MANT      = 23,
  parameter int C_TAG_WIDTH = 4
) (
  input  logic                        Clk_CI,
  input  logic                        Rst_RBI,
  input  logic                        Flush_SI,
  input  logic                        In_valid_SI,
  output logic                        In_ready_SO,
  input  logic [C_MANT+1:0]           Mant_in_DI,
  input  logic                        Sticky_in_SI,
  input  logic [C_EXP+1:0]            Exp_in_DI,
  input  logic                        Sign_in_DI,
  input  logic                        Div_enable_SI,
  input  logic                        Inf_a_SI,
  input  logic                        Inf_b_SI,
  input  logic                        Zero_a_SI,
  input  logic                        Zero_b_SI,
  input  logic                        NaN_a_SI,
  input  logic                        NaN_b_SI,
  input  logic [2:0]                  RM_SI,
  input  logic [C_TAG_WIDTH-1:0]      Tag_DI,
  output logic                        Out_valid_SO,
  input  logic                        Out_ready_SI,
  output logic [C_EXP+C_MANT:0]       Result_DO,
  output logic [4:0]                  Flags_DO,
  output logic [C_TAG_WIDTH-1:0]      Tag_DO
);

  localparam int E  = C_EXP;
  localparam int M  = C_MANT;
  localparam int EW = C_EXP + 3;

  localparam logic [E-1:0]   EXP_ONES = '1;
  localparam logic [EW-1:0]  EXP_OVF  = {3'b000, EXP_ONES};
  localparam logic [EW-1:0]  SH_MAX   = EW'(M + 3);
  localparam logic [E+M:0]   QNAN     = {1'b0, EXP_ONES, 1'b1, {(M-1){1'b0}}};

  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  logic s1_valid;
  logic s2_valid;
  logic s1_adv;
  logic in_fire;

  assign s1_adv       = ~s2_valid | Out_ready_SI;
  assign In_ready_SO  = ~s1_valid | s1_adv;
  assign in_fire      = In_valid_SI & In_ready_SO;
  assign Out_valid_SO = s2_valid;

  // Stage 1: special-operand classification
  logic           special;
  logic           spec_nv;
  logic           spec_dz;
  logic [E+M:0]   spec_res;

  always_comb begin
    special  = 1'b1;
    spec_nv  = 1'b0;
    spec_dz  = 1'b0;
    spec_res = QNAN;
    if (NaN_a_SI | NaN_b_SI) begin
      spec_nv = (NaN_a_SI & Zero_a_SI) | (NaN_b_SI & Zero_b_SI);
    end else if ((Div_enable_SI & Inf_a_SI & Inf_b_SI) |
                 (Div_enable_SI & Zero_a_SI & Zero_b_SI) |
                 (~Div_enable_SI & Sign_in_DI & ~Zero_a_SI)) begin
      spec_nv = 1'b1;
    end else if (Div_enable_SI & Zero_b_SI & ~Inf_a_SI) begin
      spec_dz  = 1'b1;
      spec_res = {Sign_in_DI, EXP_ONES, {M{1'b0}}};
    end else if (Inf_a_SI) begin
      spec_res = {Sign_in_DI, EXP_ONES, {M{1'b0}}};
    end else if ((Div_enable_SI & Inf_b_SI) | Zero_a_SI) begin
      spec_res = {Sign_in_DI, {(E+M){1'b0}}};
    end else begin
      special = 1'b0;
    end
  end

  // Stage 1: normalise, denormalise into the subnormal range when exp <= 0
  logic            int_bit;
  logic [EW-1:0]   exp_ext;
  logic [EW-1:0]   exp_norm;
  logic [EW-1:0]   shift_amt;
  logic [EW-1:0]   shift_cl;
  logic [M+1:0]    mant_norm;
  logic [M+1:0]    sub_mant;
  logic [2*M+4:0]  sh_wide;
  logic            is_sub;
  logic            is_ovf;
  logic            sub_sticky;

  assign int_bit    = Mant_in_DI[M+1];
  assign exp_ext    = {Exp_in_DI[E+1], Exp_in_DI};
  assign exp_norm   = exp_ext - {{(EW-1){1'b0}}, ~int_bit};
  assign mant_norm  = int_bit ? Mant_in_DI : {Mant_in_DI[M:0], 1'b0};
  assign is_sub     = exp_norm[EW-1] | (exp_norm == '0);
  assign is_ovf     = ~exp_norm[EW-1] & (exp_norm >= EXP_OVF);
  assign shift_amt  = EW'(1) - exp_norm;
  assign shift_cl   = (shift_amt > SH_MAX) ? SH_MAX : shift_amt;
  assign sh_wide    = {mant_norm, {(M+3){1'b0}}} >> shift_cl;
  assign sub_mant   = sh_wide[2*M+4 -: M+2];
  assign sub_sticky = |sh_wide[M+2:0];

  logic                    s1_special;
  logic                    s1_nv;
  logic                    s1_dz;
  logic [E+M:0]            s1_spec_res;
  logic                    s1_ovf;
  logic                    s1_sign;
  logic [E-1:0]            s1_exp;
  logic [M+1:0]            s1_mant;
  logic                    s1_sticky;
  logic [2:0]              s1_rm;
  logic [C_TAG_WIDTH-1:0]  s1_tag;

  always_ff @(posedge Clk_CI) begin
    if (in_fire) begin
      s1_special  <= special;
      s1_nv       <= spec_nv;
      s1_dz       <= spec_dz;
      s1_spec_res <= spec_res;
      s1_ovf      <= is_ovf;
      s1_sign     <= Sign_in_DI;
      s1_exp      <= is_sub ? '0 : exp_norm[E-1:0];
      s1_mant     <= is_sub ? sub_mant : mant_norm;
      s1_sticky   <= Sticky_in_SI | (is_sub & sub_sticky);
      s1_rm       <= RM_SI;
      s1_tag      <= Tag_DI;
    end
  end

  // Stage 2: round, then pack with overflow saturation
  logic          hidden;
  logic          guard;
  logic          nx;
  logic          up;
  logic          ovf;
  logic          ovf_inf;
  logic [M-1:0]  frac;
  logic [M+1:0]  sum;
  logic [E-1:0]  exp_r;
  logic [E+M:0]  res_n;
  logic [4:0]    flg_n;

  assign {hidden, frac, guard} = s1_mant;
  assign nx = guard | s1_sticky;

  always_comb begin
    up = 1'b0;
    case (s1_rm)
      RM_RTZ:  up = 1'b0;
      RM_RDN:  up = nx & s1_sign;
      RM_RUP:  up = nx & ~s1_sign;
      RM_RMM:  up = guard;
      default: up = guard & (s1_sticky | frac[0]);
    endcase
  end

  // A subnormal that carries into the hidden bit becomes the smallest normal
  assign sum     = {1'b0, hidden, frac} + {{(M+1){1'b0}}, up};
  assign exp_r   = (s1_exp == '0) ? {{(E-1){1'b0}}, sum[M]}
                                  : s1_exp + {{(E-1){1'b0}}, sum[M+1]};
  assign ovf     = s1_ovf | (exp_r == EXP_ONES);
  assign ovf_inf = ~((s1_rm == RM_RTZ) | ((s1_rm == RM_RUP) & s1_sign) |
                     ((s1_rm == RM_RDN) & ~s1_sign));

  always_comb begin
    res_n = {s1_sign, exp_r, sum[M-1:0]};
    flg_n = {3'b000, (exp_r == '0) & nx, nx};
    if (s1_special) begin
      res_n = s1_spec_res;
      flg_n = {s1_nv, s1_dz, 3'b000};
    end else if (ovf) begin
      res_n = ovf_inf ? {s1_sign, EXP_ONES, {M{1'b0}}}
                      : {s1_sign, EXP_ONES - E'(1), {M{1'b1}}};
      flg_n = 5'b00101;
    end
  end

  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      Result_DO <= '0;
      Flags_DO  <= '0;
      Tag_DO    <= '0;
    end else if (Flush_SI) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (In_ready_SO) s1_valid <= In_valid_SI;
      if (s1_adv) s2_valid <= s1_valid;
      if (s1_adv & s1_valid) begin
        Result_DO <= res_n;
        Flags_DO  <= flg_n;
        Tag_DO    <= s1_tag;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fpu_norm_round_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_fpu_norm_round_pipe: directed + random checks of fpu_norm_round_pipe against a value-level model
// Revision 1.0
// ============================================================================
module tb_fpu_norm_round_pipe;

  typedef struct packed {
    logic [24:0] mant;
    logic        st;
    logic [9:0]  ex;
    logic        sg;
    logic        dv;
    logic        ia, ib, za, zb, na, nb;
    logic [2:0]  rm;
    logic [3:0]  tg;
  } op_t;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  fl;
    logic [3:0]  tg;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, sticky, sign, div_en;
  logic        inf_a, inf_b, zero_a, zero_b, nan_a, nan_b;
  logic [24:0] mant;
  logic [9:0]  exp_in;
  logic [2:0]  rm;
  logic [3:0]  tag_in, tag_out;
  logic        out_valid, out_ready;
  logic [31:0] result;
  logic [4:0]  flags;

  logic        rand_mode = 1'b0;
  logic        rnd_ready = 1'b1;
  logic        forced_ready = 1'b1;
  assign out_ready = rand_mode ? rnd_ready : forced_ready;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  fpu_norm_round_pipe dut (
    .Clk_CI(clk), .Rst_RBI(rst_n), .Flush_SI(flush),
    .In_valid_SI(in_valid), .In_ready_SO(in_ready),
    .Mant_in_DI(mant), .Sticky_in_SI(sticky), .Exp_in_DI(exp_in), .Sign_in_DI(sign),
    .Div_enable_SI(div_en), .Inf_a_SI(inf_a), .Inf_b_SI(inf_b),
    .Zero_a_SI(zero_a), .Zero_b_SI(zero_b), .NaN_a_SI(nan_a), .NaN_b_SI(nan_b),
    .RM_SI(rm), .Tag_DI(tag_in),
    .Out_valid_SO(out_valid), .Out_ready_SI(out_ready),
    .Result_DO(result), .Flags_DO(flags), .Tag_DO(tag_out)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Value-level reference: the kept significand is added onto (exp-1)<<23 so carries ripple into the exponent
  function automatic void model(input op_t o, output logic [31:0] res, output logic [4:0] fl);
    int e, drop;
    longint unsigned sig, kept, pk;
    bit g, s, up, to_max;
    res = 32'h0;
    fl  = 5'b0;
    if (o.na || o.nb) begin
      res = 32'h7FC00000;
      fl[4] = (o.na && o.za) || (o.nb && o.zb);
      return;
    end
    if ((o.dv && o.ia && o.ib) || (o.dv && o.za && o.zb) || (!o.dv && o.sg && !o.za)) begin
      res = 32'h7FC00000;
      fl = 5'b10000;
      return;
    end
    if (o.dv && o.zb && !o.ia && !o.za) begin
      res = {o.sg, 8'hFF, 23'h0};
      fl = 5'b01000;
      return;
    end
    if (o.ia) begin
      res = {o.sg, 8'hFF, 23'h0};
      return;
    end
    if ((o.dv && o.ib) || o.za) begin
      res = {o.sg, 31'h0};
      return;
    end
    sig = 64'(o.mant);
    e = int'($signed(o.ex));
    if (!o.mant[24]) begin
      sig = sig << 1;
      e = e - 1;
    end
    drop = (e <= 0) ? 2 - e : 1;
    if (drop > 40) drop = 40;
    kept = sig >> drop;
    g = sig[drop-1];
    s = o.st || ((sig & ((64'd1 << (drop - 1)) - 1)) != 0);
    case (o.rm)
      3'd1:    up = 1'b0;
      3'd2:    up = (g || s) && o.sg;
      3'd3:    up = (g || s) && !o.sg;
      3'd4:    up = g;
      default: up = g && (s || kept[0]);
    endcase
    kept = kept + 64'(up);
    pk = kept;
    if (e > 0) pk = pk + (64'(e - 1) << 23);
    if (e >= 255 || pk >= (64'd255 << 23)) begin
      to_max = (o.rm == 3'd1) || (o.rm == 3'd3 && o.sg) || (o.rm == 3'd2 && !o.sg);
      res = to_max ? {o.sg, 31'h7F7FFFFF} : {o.sg, 8'hFF, 23'h0};
      fl = 5'b00101;
      return;
    end
    res = {o.sg, pk[30:0]};
    fl = {3'b000, (pk < (64'd1 << 23)) && (g || s), g || s};
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", out_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("result", result, e.res);
        check("flags", flags, e.fl);
        check("tag", tag_out, e.tg);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    rnd_ready = ($urandom_range(0, 3) != 0);
  end

  function automatic op_t mk(input logic [24:0] m, input logic st, input logic [9:0] ex,
                             input logic sg, input logic dv, input logic [2:0] r, input logic [3:0] tg);
    op_t o = '0;
    o.mant = m; o.st = st; o.ex = ex; o.sg = sg; o.dv = dv; o.rm = r; o.tg = tg;
    return o;
  endfunction

  function automatic op_t rand_op(input int i);
    op_t o = '0;
    int  ev;
    o.mant = {1'b1, 23'($urandom), 1'($urandom)};
    if ($urandom_range(0, 5) == 0) o.mant[23:1] = '1;
    if ($urandom_range(0, 4) == 0) o.mant[24:23] = 2'b01;
    o.st = 1'($urandom);
    case ($urandom_range(0, 5))
      0:       ev = int'($urandom_range(0, 35)) - 30;
      1:       ev = int'($urandom_range(248, 260));
      2:       ev = int'($urandom_range(0, 1023)) - 512;
      default: ev = int'($urandom_range(1, 254));
    endcase
    o.ex = 10'(ev);
    o.sg = 1'($urandom);
    o.dv = ($urandom_range(0, 3) != 0);
    o.ia = ($urandom_range(0, 11) == 0);
    o.ib = ($urandom_range(0, 11) == 0);
    o.za = ($urandom_range(0, 11) == 0);
    o.zb = ($urandom_range(0, 11) == 0);
    o.na = ($urandom_range(0, 15) == 0);
    o.nb = ($urandom_range(0, 15) == 0);
    o.rm = 3'($urandom_range(0, 7));
    o.tg = 4'(i);
    return o;
  endfunction

  task automatic drive(input op_t o);
    mant = o.mant; sticky = o.st; exp_in = o.ex; sign = o.sg; div_en = o.dv;
    inf_a = o.ia; inf_b = o.ib; zero_a = o.za; zero_b = o.zb; nan_a = o.na; nan_b = o.nb;
    rm = o.rm; tag_in = o.tg;
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the op
  task automatic send(input op_t o, input logic [31:0] er, input logic [4:0] ef);
    int waited = 0;
    drive(o);
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("in_ready_timeout", in_ready, 1'b1);
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back('{res: er, fl: ef, tg: o.tg});
    @(posedge clk);
    #1;
  endtask

  task automatic send_m(input op_t o);
    logic [31:0] r;
    logic [4:0]  f;
    model(o, r, f);
    send(o, r, f);
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain", exp_q.size(), 0);
  endtask

  task automatic lat_check(input op_t o, input string nm);
    send_m(o);
    in_valid = 1'b0;
    @(negedge clk);
    check({nm, "_c1"}, out_valid, 1'b0);
    @(negedge clk);
    check({nm, "_c2"}, out_valid, 1'b1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    op_t o;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
    drive('0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_result", result, 32'h0);
    check("rst_flags", flags, 5'h0);
    check("rst_tag", tag_out, 4'h0);
    check("rst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed corner cases with hand-derived expectations
    send(mk({1'b1, 23'h000001, 1'b1}, 1'b0, 10'd127, 1'b0, 1'b1, 3'd0, 4'h1), 32'h3F800002, 5'b00001);
    send(mk({1'b1, 23'h000000, 1'b1}, 1'b0, 10'd127, 1'b0, 1'b1, 3'd0, 4'h2), 32'h3F800000, 5'b00001);
    send(mk({1'b1, 23'h000000, 1'b0}, 1'b0, 10'd255, 1'b0, 1'b1, 3'd1, 4'h3), 32'h7F7FFFFF, 5'b00101);
    send(mk({1'b1, 23'h000000, 1'b0}, 1'b0, 10'd255, 1'b0, 1'b1, 3'd0, 4'h4), 32'h7F800000, 5'b00101);
    send(mk({1'b1, 23'h000000, 1'b0}, 1'b1, 10'h3FE, 1'b0, 1'b1, 3'd0, 4'h5), 32'h00100000, 5'b00011);
    o = mk(25'h1000000, 1'b0, 10'd127, 1'b0, 1'b1, 3'd0, 4'h6); o.za = 1'b1; o.zb = 1'b1;
    send(o, 32'h7FC00000, 5'b10000);
    o = mk(25'h1000000, 1'b0, 10'd127, 1'b1, 1'b1, 3'd0, 4'h7); o.zb = 1'b1;
    send(o, 32'hFF800000, 5'b01000);
    send(mk(25'h1000000, 1'b0, 10'd129, 1'b1, 1'b0, 3'd0, 4'h8), 32'h7FC00000, 5'b10000);
    send(mk({1'b1, 23'h7FFFFF, 1'b1}, 1'b0, 10'd0, 1'b0, 1'b1, 3'd0, 4'h9), 32'h00800000, 5'b00001);
    send(mk(25'h1000000, 1'b0, 10'd300, 1'b1, 1'b1, 3'd3, 4'hA), 32'hFF7FFFFF, 5'b00101);
    send(mk({1'b1, 23'h000000, 1'b1}, 1'b0, 10'd127, 1'b0, 1'b1, 3'd4, 4'hB), 32'h3F800001, 5'b00001);
    o = mk(25'h1000000, 1'b0, 10'd127, 1'b0, 1'b1, 3'd0, 4'hC); o.na = 1'b1; o.za = 1'b1;
    send(o, 32'h7FC00000, 5'b10000);
    o = mk(25'h1000000, 1'b0, 10'd127, 1'b0, 1'b1, 3'd0, 4'hD); o.nb = 1'b1;
    send(o, 32'h7FC00000, 5'b00000);
    send(mk(25'h0800000, 1'b0, 10'd128, 1'b0, 1'b1, 3'd0, 4'hE), 32'h3F800000, 5'b00000);
    drain();

    lat_check(mk(25'h1400000, 1'b0, 10'd130, 1'b0, 1'b1, 3'd0, 4'h3), "latency");
    drain();

    // Backpressure: two entries fill the pipe, the third must stall
    forced_ready = 1'b0;
    send(mk(25'h1000000, 1'b0, 10'd127, 1'b0, 1'b1, 3'd0, 4'hA), 32'h3F800000, 5'b00000);
    send(mk(25'h1000002, 1'b0, 10'd128, 1'b0, 1'b1, 3'd0, 4'hB), 32'h40000001, 5'b00000);
    drive(mk(25'h1000004, 1'b0, 10'd129, 1'b1, 1'b1, 3'd0, 4'hC));
    in_valid = 1'b1;
    @(negedge clk);
    check("bp_stall", in_ready, 1'b0);
    check("bp_hold_tag", tag_out, 4'hA);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_hold_result", result, 32'h3F800000);
    check("bp_still_stalled", in_ready, 1'b0);
    @(posedge clk);
    #1;
    forced_ready = 1'b1;
    send(mk(25'h1000004, 1'b0, 10'd129, 1'b1, 1'b1, 3'd0, 4'hC), 32'hC0800002, 5'b00000);
    send(mk(25'h1000006, 1'b0, 10'd130, 1'b0, 1'b1, 3'd0, 4'hD), 32'h41000003, 5'b00000);
    drain();

    // Flush with two in flight; the op offered alongside the flush is dropped
    forced_ready = 1'b0;
    send_m(mk(25'h1000000, 1'b0, 10'd100, 1'b0, 1'b1, 3'd0, 4'h1));
    send_m(mk(25'h1000000, 1'b0, 10'd101, 1'b0, 1'b1, 3'd0, 4'h2));
    drive(mk(25'h1000000, 1'b0, 10'd102, 1'b0, 1'b1, 3'd0, 4'h3));
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    forced_ready = 1'b1;
    lat_check(mk(25'h1200000, 1'b0, 10'd140, 1'b0, 1'b1, 3'd2, 4'h7), "post_flush");
    drain();

    // Reset mid-stream
    forced_ready = 1'b0;
    send_m(mk(25'h1000000, 1'b0, 10'd90, 1'b0, 1'b1, 3'd0, 4'h4));
    send_m(mk(25'h1000000, 1'b0, 10'd91, 1'b0, 1'b1, 3'd0, 4'h5));
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_result", result, 32'h0);
    @(posedge clk);
    #1;
    forced_ready = 1'b1;
    lat_check(mk(25'h1300000, 1'b1, 10'd20, 1'b0, 1'b1, 3'd3, 4'h9), "post_reset");
    drain();

    // Random traffic with random consumer backpressure
    rand_mode = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      send_m(rand_op(i));
    end
    drain();
    rand_mode = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
